multicyc_ctrl_fsm: RTL and testbench

Main control state machine for the multicycle MIPS core. It sequences one shared ALU, one shared memory port, the instruction register and the register file across fetch/decode/execute/memory/write-back states. It takes opcode and funct from the instruction register and a ready handshake from memory, and drives every datapath enable and mux select. It replaces the single-cycle combinational control unit when the core moves to the multicycle datapath.

---
 rtl/multicyc_ctrl_fsm_if.sv | 39 +++
 rtl/multicyc_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 tb/tb_multicyc_ctrl_fsm.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/multicyc_ctrl_fsm_if.sv
// Control bus of the multicycle MIPS controller: instruction fields and memory
// handshake going in, every datapath enable/select coming out.
// master = the control FSM, slave = the datapath side.
interface multicyc_ctrl_fsm_if;
   logic [5:0] iOpCode;
   logic [5:0] iFunct;
   logic       iMemReady;
   logic       oPCWrite;
   logic       oPCWriteCond;
   logic       oBranchEq;
   logic       oIorD;
   logic       oMemRead;
   logic       oMemWrite;
   logic       oIRWrite;
   logic [1:0] oRegDst;
   logic [1:0] oMemtoReg;
   logic       oRegWrite;
   logic       oALUSrcA;
   logic [1:0] oALUSrcB;
   logic [1:0] oALUOp;
   logic [1:0] oPCSource;
   logic [3:0] oState;
   logic       oRetire;
   logic       oIllegal;

   modport master (
      input  iOpCode, iFunct, iMemReady,
      output oPCWrite, oPCWriteCond, oBranchEq, oIorD, oMemRead, oMemWrite,
             oIRWrite, oRegDst, oMemtoReg, oRegWrite, oALUSrcA, oALUSrcB,
             oALUOp, oPCSource, oState, oRetire, oIllegal
   );

   modport slave (
      output iOpCode, iFunct, iMemReady,
      input  oPCWrite, oPCWriteCond, oBranchEq, oIorD, oMemRead, oMemWrite,
             oIRWrite, oRegDst, oMemtoReg, oRegWrite, oALUSrcA, oALUSrcB,
             oALUOp, oPCSource, oState, oRetire, oIllegal
   );
endinterface

// File: rtl/multicyc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS core. Sequences fetch, decode,
// execute, memory and write-back over one shared ALU and memory port.
// Outputs are decoded combinationally from the state (and iMemReady in the
// memory-wait states) and are forced to zero while iRst_n is low.
// Optional feature: define MULTICYC_JAL_EN to add JAL, JR and JALR support.
module multicyc_ctrl_fsm (
   input  logic                   iClk,
   input  logic                   iRst_n,
   multicyc_ctrl_fsm_if.master    bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11,
      S_JAL    = 4'd12,
      S_JR     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
`ifdef MULTICYC_JAL_EN
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
`endif

   state_t     stateR;
   state_t     nextState;
   logic       pcWrite, pcWriteCond, branchEq, iorD, memRead, memWrite;
   logic       irWrite, regWrite, aluSrcA, retire, illegal;
   logic [1:0] regDst, memtoReg, aluSrcB, aluOp, pcSource;

`ifndef MULTICYC_JAL_EN
   // funct is only decoded by the ALU control when jump-register support is off
   logic unusedFunct;
   assign unusedFunct = ^bus.iFunct;
`endif

   // State register: asynchronous return to FETCH on reset
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stateR <= S_FETCH;
      end else begin
         stateR <= nextState;
      end
   end

   // Next-state and control decode; everything defaults to zero/hold
   always_comb begin
      nextState   = stateR;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      branchEq    = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regDst      = 2'b00;
      memtoReg    = 2'b00;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
      retire      = 1'b0;
      illegal     = 1'b0;
      if (!iRst_n) begin
         // reset held: all controls stay quiet so no write can slip through
         nextState = S_FETCH;
      end else begin
         case (stateR)
            S_FETCH: begin
               memRead = 1'b1;
               aluSrcB = 2'b01;
               irWrite = bus.iMemReady;
               pcWrite = bus.iMemReady;
               if (bus.iMemReady) begin
                  nextState = S_DECODE;
               end else begin
                  nextState = S_FETCH;
               end
            end
            S_DECODE: begin
               // branch target is precomputed into ALUOut here
               aluSrcB = 2'b11;
               case (bus.iOpCode)
                  OP_RTYPE: begin
`ifdef MULTICYC_JAL_EN
                     if ((bus.iFunct == FN_JR) || (bus.iFunct == FN_JALR)) begin
                        nextState = S_JR;
                     end else begin
                        nextState = S_EXEC;
                     end
`else
                     nextState = S_EXEC;
`endif
                  end
                  OP_LW, OP_SW:     nextState = S_MEMADR;
                  OP_BEQ, OP_BNE:   nextState = S_BRANCH;
                  OP_J:             nextState = S_JUMP;
                  OP_ADDI, OP_ADDIU: nextState = S_IEXEC;
`ifdef MULTICYC_JAL_EN
                  OP_JAL:           nextState = S_JAL;
`endif
                  default: begin
                     illegal   = 1'b1;
                     nextState = S_FETCH;
                  end
               endcase
            end
            S_MEMADR: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               if (bus.iOpCode == OP_LW) begin
                  nextState = S_MEMRD;
               end else if (bus.iOpCode == OP_SW) begin
                  nextState = S_MEMWR;
               end else begin
                  nextState = S_FETCH;
               end
            end
            S_MEMRD: begin
               memRead = 1'b1;
               iorD    = 1'b1;
               if (bus.iMemReady) begin
                  nextState = S_MEMWB;
               end else begin
                  nextState = S_MEMRD;
               end
            end
            S_MEMWB: begin
               regWrite  = 1'b1;
               memtoReg  = 2'b01;
               retire    = 1'b1;
               nextState = S_FETCH;
            end
            S_MEMWR: begin
               memWrite = 1'b1;
               iorD     = 1'b1;
               retire   = bus.iMemReady;
               if (bus.iMemReady) begin
                  nextState = S_FETCH;
               end else begin
                  nextState = S_MEMWR;
               end
            end
            S_EXEC: begin
               aluSrcA   = 1'b1;
               aluOp     = 2'b10;
               nextState = S_RWB;
            end
            S_RWB: begin
               regWrite  = 1'b1;
               regDst    = 2'b01;
               retire    = 1'b1;
               nextState = S_FETCH;
            end
            S_BRANCH: begin
               aluSrcA     = 1'b1;
               aluOp       = 2'b01;
               pcWriteCond = 1'b1;
               pcSource    = 2'b01;
               branchEq    = (bus.iOpCode == OP_BEQ);
               retire      = 1'b1;
               nextState   = S_FETCH;
            end
            S_JUMP: begin
               pcWrite   = 1'b1;
               pcSource  = 2'b10;
               retire    = 1'b1;
               nextState = S_FETCH;
            end
            S_IEXEC: begin
               aluSrcA   = 1'b1;
               aluSrcB   = 2'b10;
               nextState = S_IWB;
            end
            S_IWB: begin
               regWrite  = 1'b1;
               retire    = 1'b1;
               nextState = S_FETCH;
            end
`ifdef MULTICYC_JAL_EN
            S_JAL: begin
               pcWrite   = 1'b1;
               pcSource  = 2'b10;
               regWrite  = 1'b1;
               regDst    = 2'b10;
               memtoReg  = 2'b10;
               retire    = 1'b1;
               nextState = S_FETCH;
            end
            S_JR: begin
               pcWrite  = 1'b1;
               pcSource = 2'b11;
               retire   = 1'b1;
               if (bus.iFunct == FN_JALR) begin
                  regWrite = 1'b1;
                  regDst   = 2'b01;
                  memtoReg = 2'b10;
               end else begin
                  regWrite = 1'b0;
               end
               nextState = S_FETCH;
            end
`endif
            default: begin
               nextState = S_FETCH;
            end
         endcase
      end
   end

   assign bus.oPCWrite     = pcWrite;
   assign bus.oPCWriteCond = pcWriteCond;
   assign bus.oBranchEq    = branchEq;
   assign bus.oIorD        = iorD;
   assign bus.oMemRead     = memRead;
   assign bus.oMemWrite    = memWrite;
   assign bus.oIRWrite     = irWrite;
   assign bus.oRegDst      = regDst;
   assign bus.oMemtoReg    = memtoReg;
   assign bus.oRegWrite    = regWrite;
   assign bus.oALUSrcA     = aluSrcA;
   assign bus.oALUSrcB     = aluSrcB;
   assign bus.oALUOp       = aluOp;
   assign bus.oPCSource    = pcSource;
   assign bus.oState       = stateR;
   assign bus.oRetire      = retire;
   assign bus.oIllegal     = illegal;

endmodule

// File: tb/tb_multicyc_ctrl_fsm.sv
// Scoreboard bench for multicyc_ctrl_fsm. The driver expands each instruction
// into an expected state-per-cycle list and an expected end-of-instruction
// event; a negedge monitor pops and compares. Honours MULTICYC_JAL_EN.
module tb_multicyc_ctrl_fsm;

`ifdef MULTICYC_JAL_EN
   localparam bit JAL_EN = 1'b1;
`else
   localparam bit JAL_EN = 1'b0;
`endif

   typedef struct {
      logic       retire;
      logic       illegal;
      logic [3:0] state;
      logic       pcWrite;
      logic       pcWriteCond;
      logic       branchEq;
      logic       regWrite;
      logic [1:0] regDst;
      logic [1:0] memtoReg;
      logic [1:0] pcSource;
   } ev_t;

   logic iClk;
   logic iRst_n;
   multicyc_ctrl_fsm_if bus ();

   multicyc_ctrl_fsm dut (.iClk(iClk), .iRst_n(iRst_n), .bus(bus));

   int total = 0;
   int bad   = 0;
   int stateQ[$];
   ev_t evQ[$];
   int irCount = 0;

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] packEv(input ev_t e);
      return {e.retire, e.illegal, e.state, e.pcWrite, e.pcWriteCond, e.branchEq,
              e.regWrite, e.regDst, e.memtoReg, e.pcSource};
   endfunction

   // Monitor: per-cycle state and request checks, event checks on retire/illegal
   always @(negedge iClk) begin
      if (!iRst_n) begin
         irCount = 0;
      end else begin
         if (bus.oIRWrite) irCount++;
         if (stateQ.size() > 0) check("state", 32'(bus.oState), 32'(stateQ.pop_front()));
         if (bus.oState == 4'd0)
            check("fetch_req", {29'd0, bus.oMemRead, bus.oIorD, bus.oMemWrite}, 32'b100);
         if (bus.oState == 4'd0) check("fetch_irw", 32'(bus.oIRWrite), 32'(bus.iMemReady));
         if (bus.oState == 4'd3)
            check("memrd_req", {29'd0, bus.oMemRead, bus.oIorD, bus.oMemWrite}, 32'b110);
         if (bus.oState == 4'd5)
            check("memwr_req", {29'd0, bus.oMemRead, bus.oIorD, bus.oMemWrite}, 32'b011);
         if (bus.oRetire || bus.oIllegal) begin
            if (evQ.size() == 0) begin
               check("unexpected_event", 32'(bus.oState), 32'hffff_ffff);
            end else begin
               ev_t e;
               e = evQ.pop_front();
               check("event", {16'd0, bus.oRetire, bus.oIllegal, bus.oState, bus.oPCWrite,
                     bus.oPCWriteCond, bus.oBranchEq, bus.oRegWrite, bus.oRegDst,
                     bus.oMemtoReg, bus.oPCSource}, {16'd0, packEv(e)});
               check("irwrite_once", 32'(irCount), 32'd1);
            end
            irCount = 0;
         end
      end
   end

   // Reference model + driver: one instruction with f fetch stalls, m memory stalls
   task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int f, input int m);
      int   st[$];
      logic rd[$];
      ev_t  e;
      e = '{retire: 1'b1, illegal: 1'b0, state: 4'd0, pcWrite: 1'b0, pcWriteCond: 1'b0,
            branchEq: 1'b0, regWrite: 1'b0, regDst: 2'b00, memtoReg: 2'b00, pcSource: 2'b00};
      for (int i = 0; i < f; i++) begin st.push_back(0); rd.push_back(1'b0); end
      st.push_back(0); rd.push_back(1'b1);
      st.push_back(1); rd.push_back(1'($urandom));
      if (op == 6'h00 && JAL_EN && (fn == 6'h08 || fn == 6'h09)) begin
         st.push_back(13); rd.push_back(1'($urandom));
         e.state = 4'd13; e.pcWrite = 1'b1; e.pcSource = 2'b11;
         if (fn == 6'h09) begin e.regWrite = 1'b1; e.regDst = 2'b01; e.memtoReg = 2'b10; end
      end else if (op == 6'h00 || op == 6'h08 || op == 6'h09) begin
         st.push_back(op == 6'h00 ? 6 : 10); rd.push_back(1'($urandom));
         st.push_back(op == 6'h00 ? 7 : 11); rd.push_back(1'($urandom));
         e.state = (op == 6'h00) ? 4'd7 : 4'd11; e.regWrite = 1'b1;
         e.regDst = (op == 6'h00) ? 2'b01 : 2'b00;
      end else if (op == 6'h23 || op == 6'h2b) begin
         int w;
         w = (op == 6'h23) ? 3 : 5;
         st.push_back(2); rd.push_back(1'($urandom));
         for (int i = 0; i < m; i++) begin st.push_back(w); rd.push_back(1'b0); end
         st.push_back(w); rd.push_back(1'b1);
         if (op == 6'h23) begin
            st.push_back(4); rd.push_back(1'($urandom));
            e.state = 4'd4; e.regWrite = 1'b1; e.memtoReg = 2'b01;
         end else begin
            e.state = 4'd5;
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         st.push_back(8); rd.push_back(1'($urandom));
         e.state = 4'd8; e.pcWriteCond = 1'b1; e.pcSource = 2'b01; e.branchEq = (op == 6'h04);
      end else if (op == 6'h02) begin
         st.push_back(9); rd.push_back(1'($urandom));
         e.state = 4'd9; e.pcWrite = 1'b1; e.pcSource = 2'b10;
      end else if (op == 6'h03 && JAL_EN) begin
         st.push_back(12); rd.push_back(1'($urandom));
         e.state = 4'd12; e.pcWrite = 1'b1; e.pcSource = 2'b10; e.regWrite = 1'b1;
         e.regDst = 2'b10; e.memtoReg = 2'b10;
      end else begin
         e.retire = 1'b0; e.illegal = 1'b1; e.state = 4'd1;
      end
      foreach (st[i]) stateQ.push_back(st[i]);
      evQ.push_back(e);
      bus.iOpCode = op;
      bus.iFunct  = fn;
      foreach (rd[i]) begin
         bus.iMemReady = rd[i];
         @(posedge iClk); #1;
      end
   endtask

   // Watchdog: the run must never hang
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Stimulus sequence
   initial begin
      logic [5:0] ops [10];
      ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h09, 6'h03, 6'h3f};
      iRst_n = 1'b0;
      bus.iOpCode = 6'h00; bus.iFunct = 6'h20; bus.iMemReady = 1'b1;
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      check("rst_state", 32'(bus.oState), 32'd0);
      check("rst_ctrl", {25'd0, bus.oMemRead, bus.oPCWrite, bus.oIRWrite, bus.oRetire,
            bus.oIllegal, bus.oMemWrite, bus.oRegWrite}, 32'd0);
      check("rst_sel", {24'd0, bus.oALUSrcB, bus.oPCSource, bus.oRegDst, bus.oMemtoReg}, 32'd0);
      @(posedge iClk); #1;
      iRst_n = 1'b1;

      // directed: R-type add, LW with 2+2 stalls, BNE, illegal 3f, JAL, JR/JALR
      runInstr(6'h00, 6'h20, 0, 0);
      runInstr(6'h23, 6'h00, 2, 2);
      runInstr(6'h05, 6'h00, 0, 0);
      runInstr(6'h3f, 6'h00, 0, 0);
      runInstr(6'h03, 6'h00, 0, 0);
      runInstr(6'h00, 6'h08, 1, 0);
      runInstr(6'h00, 6'h09, 0, 0);
      runInstr(6'h2b, 6'h00, 1, 3);

      // randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         logic [5:0] op;
         logic [5:0] fn;
         op = ops[$urandom_range(0, 9)];
         if (op == 6'h3f) op = 6'($urandom);
         fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(8, 9)) : 6'($urandom);
         runInstr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // idle in FETCH, then confirm everything expected was seen
      bus.iMemReady = 1'b0;
      repeat (3) @(posedge iClk);
      #1;
      check("stateq_drained", 32'(stateQ.size()), 32'd0);
      check("evq_drained", 32'(evQ.size()), 32'd0);

      // reset in the middle of a stalled store
      bus.iOpCode = 6'h2b; bus.iMemReady = 1'b1;
      repeat (3) @(posedge iClk);
      #1 bus.iMemReady = 1'b0;
      @(negedge iClk);
      check("memwr_state", 32'(bus.oState), 32'd5);
      check("memwr_write", 32'(bus.oMemWrite), 32'd1);
      #2 iRst_n = 1'b0;
      #1;
      check("rst_mid_write", 32'(bus.oMemWrite), 32'd0);
      check("rst_mid_state", 32'(bus.oState), 32'd0);
      check("rst_mid_read", 32'(bus.oMemRead), 32'd0);
      @(posedge iClk); #1;
      iRst_n = 1'b1;
      @(negedge iClk);
      check("post_rst_fetch", 32'(bus.oState), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
